// File: rtl/neurosync_medidor_faixa.sv
// neurosync_medidor_faixa: ultrasonic range meter with consecutive in-range hit detection
module neurosync_medidor_faixa #(
  parameter int TRIG_CYCLES     = 500,
  parameter int CM_CYCLES       = 2941,
  parameter int ECHO_TIMEOUT    = 1500000,
  parameter int INTERVAL_CYCLES = 3000000,
  parameter int HITS_REQ        = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       medir,
  input  logic       echo,
  input  logic [8:0] faixa_min,
  input  logic [8:0] faixa_max,
  output logic       trigger,
  output logic [8:0] distancia,
  output logic       pronto,
  output logic       medida_valida,
  output logic       acertou_faixa
);
  localparam int M1 = TRIG_CYCLES > CM_CYCLES ? TRIG_CYCLES : CM_CYCLES;
  localparam int M2 = ECHO_TIMEOUT > INTERVAL_CYCLES ? ECHO_TIMEOUT : INTERVAL_CYCLES;
  localparam int MX = M1 > M2 ? M1 : M2;
  localparam int CW = $clog2(MX + 1);
  localparam int HW = $clog2(HITS_REQ + 1);
  typedef enum logic [2:0] {IDLE, TRIG, ESPERA_ECO, MEDE, AVALIA, INTERVALO} state_t;
  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [8:0] cm, cm_n;
  logic [HW-1:0] hits;
  logic echo_m, echo_s, echo_d, rise, wrap, ok, in_range, enter_av;
  assign rise     = echo_s & ~echo_d;
  assign wrap     = cnt == CW'(CM_CYCLES - 1);
  assign cm_n     = cm + 9'(wrap);
  assign in_range = cm_n >= faixa_min && cm_n <= faixa_max;
  assign enter_av = nxt == AVALIA;
  assign trigger  = st == TRIG;
  always_comb begin
    nxt = st;
    ok  = 1'b0;
    case (st)
      IDLE:       nxt = medir ? TRIG : IDLE;
      TRIG:       nxt = cnt == CW'(TRIG_CYCLES - 1) ? ESPERA_ECO : TRIG;
      ESPERA_ECO: nxt = rise ? MEDE : cnt == CW'(ECHO_TIMEOUT - 1) ? AVALIA : ESPERA_ECO;
      // the falling cycle is counted too, so the edge-detect cycle spent in ESPERA_ECO is not lost
      MEDE: begin
        nxt = (wrap && cm == 9'd510) || !echo_s ? AVALIA : MEDE;
        ok  = !echo_s && !(wrap && cm == 9'd510);
      end
      AVALIA:     nxt = INTERVALO;
      INTERVALO:  nxt = cnt == CW'(INTERVAL_CYCLES - 1) ? TRIG : INTERVALO;
      default:    nxt = IDLE;
    endcase
    if (!medir) nxt = IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      st            <= IDLE;
      echo_m        <= 1'b0;
      echo_s        <= 1'b0;
      echo_d        <= 1'b0;
      cnt           <= '0;
      cm            <= '0;
      hits          <= '0;
      distancia     <= '0;
      pronto        <= 1'b0;
      medida_valida <= 1'b0;
      acertou_faixa <= 1'b0;
    end else begin
      st            <= nxt;
      echo_m        <= echo;
      echo_s        <= echo_m;
      echo_d        <= echo_s;
      cnt           <= (st == IDLE || nxt != st || (st == MEDE && wrap)) ? '0 : cnt + 1'b1;
      cm            <= st == MEDE ? cm_n : '0;
      pronto        <= enter_av;
      medida_valida <= enter_av ? ok : medida_valida;
      distancia     <= enter_av && ok ? cm_n : distancia;
      hits          <= nxt == IDLE ? '0 :
                       !enter_av ? hits :
                       !(ok && in_range) ? '0 :
                       hits == HW'(HITS_REQ) ? hits : hits + 1'b1;
      acertou_faixa <= medir && hits == HW'(HITS_REQ);
    end
  end
endmodule

// File: doc/neurosync_medidor_faixa.md
NEUROSYNC_MEDIDOR_FAIXA -- requirements
Module: neurosync_medidor_faixa

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  TRIG_CYCLES, 500, trigger pulse width in clocks (10 us at 50 MHz).
  CM_CYCLES, 2941, clocks of echo-high per centimetre.
  ECHO_TIMEOUT, 1500000, max clocks waiting for echo rise.
  INTERVAL_CYCLES, 3000000, idle gap between measurements (60 ms).
  HITS_REQ, 3, consecutive in-range samples needed for a hit.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clock  in  1  system clock; single clock domain.
  reset  in  1  synchronous, active-high reset.
  medir  in  1  level enable from the game controller (high while awaiting range answer).
  echo  in  1  asynchronous sensor echo pin.
  faixa_min  in  9  lower bound of target range, cm, inclusive.
  faixa_max  in  9  upper bound of target range, cm, inclusive.
  trigger  out  1  sensor trigger pulse.
  distancia  out  9  last valid distance, cm.
  pronto  out  1  one-cycle pulse per completed measurement.
  medida_valida  out  1  qualifier of the latest measurement, held until the next pronto.
  acertou_faixa  out  1  level, high once HITS_REQ consecutive valid in-range samples are seen.

Function
REQ-003 echo SHALL pass through a 2-flop synchronizer (echo_s); all logic SHALL use echo_s only.
REQ-004 FSM states SHALL be IDLE, TRIG, ESPERA_ECO, MEDE, AVALIA, INTERVALO.
REQ-005 IDLE: medir=1 -> TRIG on the next edge; otherwise stay in IDLE.
REQ-006 TRIG: trigger=1 for exactly TRIG_CYCLES clocks, then -> ESPERA_ECO; trigger SHALL be 0 in every other state.
REQ-007 ESPERA_ECO: echo_s=1 -> MEDE; ECHO_TIMEOUT clocks elapsed without a rise -> AVALIA with the sample marked invalid.
REQ-008 MEDE: sub-counter SHALL count 0..CM_CYCLES-1 while echo_s=1; each wrap SHALL increment the working cm count (truncating); echo_s=0 -> AVALIA valid.
REQ-009 MEDE: working cm count reaching 511 -> AVALIA with the sample marked invalid (saturation, no wrap).
REQ-010 AVALIA SHALL last one clock: pronto=1; medida_valida SHALL be set to the validity; distancia SHALL load the working count only if valid, else hold.
REQ-011 Hit counter update in AVALIA: valid and faixa_min<=count<=faixa_max -> min(hits+1, HITS_REQ); otherwise -> 0.
REQ-012 faixa_min>faixa_max SHALL never count as in range.
REQ-013 acertou_faixa SHALL be registered as (hits==HITS_REQ), asserting the cycle after the qualifying AVALIA.
REQ-014 acertou_faixa SHALL stay high while medir=1 and subsequent samples keep hits at HITS_REQ; an invalid or out-of-range sample SHALL drop it the cycle after AVALIA.
REQ-015 AVALIA -> INTERVALO; INTERVALO SHALL wait INTERVAL_CYCLES clocks, then -> TRIG if medir=1, else -> IDLE.
REQ-016 medir=0 in any non-IDLE state SHALL force IDLE on the next edge: trigger=0, counters, hits and acertou_faixa cleared; distancia and medida_valida held.
REQ-017 medir=0 has priority over all other transitions.
REQ-018 Echo still high on entry to TRIG SHALL be ignored; ESPERA_ECO SHALL only accept an echo_s rise after trigger ends.
REQ-019 All counters SHALL be sized for their parameter maximum and clear on every state entry.

Reset
REQ-020 reset=1 at a clock edge SHALL force IDLE and zero trigger, distancia, pronto, medida_valida, acertou_faixa, hits and all counters, including mid-measurement.
REQ-021 The synchronizer flops SHALL also clear on reset.

Verification (TRIG_CYCLES=4, CM_CYCLES=10, ECHO_TIMEOUT=100, INTERVAL_CYCLES=50, HITS_REQ=3)
REQ-022 medir=1, echo high for 250 clocks, range 20..30 -> trigger high exactly 4 clocks; pronto pulse; distancia=25; medida_valida=1; acertou_faixa still 0.
REQ-023 Three consecutive 250-clock echoes, range 20..30 -> acertou_faixa=1 one cycle after the third pronto; fourth echo of 400 clocks (40 cm) -> acertou_faixa=0 after that pronto.
REQ-024 No echo -> pronto after 100 clocks in ESPERA_ECO; medida_valida=0; distancia unchanged; hits=0.
REQ-025 Echo held high 6000 clocks -> saturation at 511; medida_valida=0; distancia holds the prior value.
REQ-026 medir dropped mid-MEDE, then reset asserted in TRIG -> IDLE next edge both times; trigger=0; acertou_faixa=0; after reset every output is 0.
REQ-027 Range 30..20 with a 250-clock echo -> medida_valida=1; distancia=25; acertou_faixa never asserts.
